pcie_rx_tlp_parser: RTL and testbench
=====================================

# pcie_rx_tlp_parser

Receive-side TLP parser placed directly downstream of the PCIe endpoint's 32-bit AXI-Stream RX port (`m_axis_rx_*`). It splits each incoming TLP into a header descriptor and a payload stream so that the write/read/completion handlers never see raw header DWs. Poisoned and unsupported TLPs are dropped here and counted, and length/framing violations are flagged.

## Interface
Parameters:
- `MAX_PAYLOAD_DW`, 128: largest accepted payload in DWs; anything larger is malformed.

Ports:
- `clk`  in  1  user clock, the endpoint's `user_clk_out`.
- `rst_n`  in  1  reset, synchronous, active-low.
- `m_axis_rx_tdata`  in  32  TLP DW; byte 0 is `[31:24]`.
- `m_axis_rx_tkeep`  in  4  ignored; every beat is a full DW.
- `m_axis_rx_tlast`  in  1  last DW of TLP.
- `m_axis_rx_tvalid`  in  1  beat valid.
- `m_axis_rx_tready`  out  1  beat accepted when high together with `tvalid`.
- `m_axis_rx_tuser`  in  22  `[8:2]` BAR hit; sampled on DW0.
- `o_hdr_valid`  out  1  header descriptor valid.
- `i_hdr_ready`  in  1  descriptor consumed.
- `o_hdr_kind`  out  2  0=MRd, 1=MWr, 2=Cpl, 3=CplD.
- `o_hdr_length`  out  11  payload DWs, 1..1024.
- `o_hdr_req_id`  out  16  requester ID.
- `o_hdr_tag`  out  8  tag.
- `o_hdr_first_be`  out  4  first DW byte enables (requests only).
- `o_hdr_last_be`  out  4  last DW byte enables (requests only).
- `o_hdr_addr`  out  64  byte address, `[1:0]`=0; upper half 0 for 3DW headers.
- `o_hdr_bar_hit`  out  7  BAR hit latched at DW0.
- `o_cpl_status`  out  3  completion status.
- `o_cpl_byte_count`  out  12  completion byte count.
- `o_cpl_lower_addr`  out  7  completion lower address.
- `o_data`  out  32  payload DW.
- `o_data_valid`  out  1  payload beat valid.
- `i_data_ready`  in  1  payload beat accepted.
- `o_data_last`  out  1  final payload DW.
- `o_err_malformed`  out  1  one-cycle pulse on a framing or length error.
- `o_drop_count`  out  16  count of dropped TLPs; saturates at 0xFFFF.

## Operation
- **States:** H0, H1, H2, H3, HDR_OUT, DATA, DRAIN.
- **H0:**
  - Latch `fmt=[30:29]`, `type=[28:24]`, `EP=[14]`, `length=[9:0]`; a length field of 0 means 1024.
  - 4DW header when `fmt[0]`; payload present when `fmt[1]`.
  - Supported `{fmt,type}`: MRd 0x00/0x20, MWr 0x40/0x60, Cpl 0x0A, CplD 0x4A. Anything else is unsupported.
- **H1:**
  - Requests: `req_id=[31:16]`, `tag=[15:8]`, `last_be=[7:4]`, `first_be=[3:0]`.
  - Completions: `status=[15:13]`, `byte_count=[11:0]`.
- **H2:**
  - Completions: `req_id=[31:16]`, `tag=[15:8]`, `lower_addr=[6:0]`.
  - 3DW requests: `addr[31:2]`.
  - 4DW requests: `addr[63:32]`.
- **H3 (4DW only):** `addr[31:2]`.
- **Header DW handling:** `m_axis_rx_tready=1` in H0 through H3.
- **Last header DW:**
  - Unsupported type, `EP=1`, or payload length > `MAX_PAYLOAD_DW`: increment `o_drop_count` and go to DRAIN. The oversize case also pulses `o_err_malformed`. If `tlast` is already high on this beat, go to H0 instead of DRAIN.
  - `tlast` disagrees with payload presence: pulse `o_err_malformed`, emit no header, go to H0 if `tlast` is high, else DRAIN.
  - Otherwise go to HDR_OUT.
- **Early `tlast`:** `tlast` on any header DW before the last one pulses `o_err_malformed`, emits no header, and returns to H0.
- **HDR_OUT:**
  - `tready=0`, `o_hdr_valid=1`.
  - On `i_hdr_ready`: go to DATA if payload present, else H0.
- **DATA:**
  - Pass-through: `o_data=tdata`, `o_data_valid=tvalid`, `tready=i_data_ready`.
  - An 11-bit down-counter is loaded with the length.
  - `o_data_last` is high when the count equals 1, or when `tlast` is high.
- **DATA boundaries:**
  - `tlast` with count>1: pulse `o_err_malformed`; the beat is delivered with `o_data_last=1`; go to H0.
  - count==1 without `tlast`: pulse `o_err_malformed`; the beat is delivered with `o_data_last=1`; go to DRAIN.
  - count==1 with `tlast`: go to H0.
- **DRAIN:** `tready=1`, beats discarded, go to H0 on `tlast`.

## Timing
- **Reset values:** while `rst_n=0` every output is 0, including `tready`, `o_drop_count` and all descriptor fields. The state is H0. `tready` rises the first cycle after reset is released.
- **Header latency:** `o_hdr_valid` rises the cycle after the last header DW is accepted. All descriptor fields are registered and stable while `o_hdr_valid` is high.
- **Data path:** zero-latency combinational path from `m_axis_rx_*` to `o_data*` in DATA. `i_data_ready` feeds back combinationally to `tready`.
- **Header/payload ordering:** a payload beat is never accepted before its header has been accepted.
- **Back-to-back TLPs:** a 3DW MRd occupies 3 accept cycles plus 1 HDR_OUT cycle when `i_hdr_ready` is held high.
- **Reset mid-TLP:** abandon the TLP, state to H0, no error pulse. The next `tvalid` beat is treated as DW0.

## Test plan
- **3DW MWr:** DW0=0x40000004, DW1=0x01000A0F, DW2=0x00001000, payload 0x11..0x44 with `tlast` on 0x44 -> one descriptor with kind=1, length=4, req_id=0x0100, tag=0x0A, be=F/0, addr=0x1000; then 4 data beats with `o_data_last` on 0x44.
- **3DW MRd, length=1, `i_hdr_ready` held 0 for 5 cycles:** `tready=0` throughout; the descriptor is held stable; no data beats.
- **4DW MWr with addr 0x1_0000_2000, 1 DW:** `o_hdr_addr=0x0000000100002000`.
- **CplD with status 0, byte_count=8, lower_addr=0x10, 2 DW:** kind=3; cpl fields match; 2 data beats.
- **MWr length 4 with `tlast` on the 2nd payload DW:** `o_err_malformed` pulses once; `o_data_last` on beat 2; the next TLP parses correctly.
- **Poisoned MWr (EP=1), then a message TLP (type 0x14):** `o_drop_count=2`; no descriptors; no data beats.
- **`rst_n` low during H2 of an MRd:** no descriptor is emitted; a subsequent clean MRd parses normally.

Source files
------------

// File: rtl/pcie_rx_tlp_parser.sv
// -----------------------------------------------------------------------------
// pcie_rx_tlp_parser
//
// Sits behind the endpoint's 32-bit AXI-Stream RX port and splits every TLP
// into a registered header descriptor and a zero-latency payload stream.
// Poisoned, unsupported and oversize TLPs are drained and counted; framing
// violations (tlast in the wrong place) raise a one-cycle error pulse.
//
// Ports
//   clk, rst_n            user clock, synchronous active-low reset
//   m_axis_rx_*           incoming TLP stream (tkeep ignored, tuser[8:2]=BAR)
//   o_hdr_valid/i_hdr_ready   header descriptor handshake
//   o_hdr_*, o_cpl_*      descriptor fields, stable while o_hdr_valid is high
//   o_data*, i_data_ready payload pass-through, o_data_last on final DW
//   o_err_malformed       one-cycle pulse on framing/length error
//   o_drop_count          saturating count of dropped TLPs
// -----------------------------------------------------------------------------
module pcie_rx_tlp_parser #(
    parameter int MAX_PAYLOAD_DW = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] m_axis_rx_tdata,
    input  logic [3:0]  m_axis_rx_tkeep,
    input  logic        m_axis_rx_tlast,
    input  logic        m_axis_rx_tvalid,
    output logic        m_axis_rx_tready,
    input  logic [21:0] m_axis_rx_tuser,
    output logic        o_hdr_valid,
    input  logic        i_hdr_ready,
    output logic [1:0]  o_hdr_kind,
    output logic [10:0] o_hdr_length,
    output logic [15:0] o_hdr_req_id,
    output logic [7:0]  o_hdr_tag,
    output logic [3:0]  o_hdr_first_be,
    output logic [3:0]  o_hdr_last_be,
    output logic [63:0] o_hdr_addr,
    output logic [6:0]  o_hdr_bar_hit,
    output logic [2:0]  o_cpl_status,
    output logic [11:0] o_cpl_byte_count,
    output logic [6:0]  o_cpl_lower_addr,
    output logic [31:0] o_data,
    output logic        o_data_valid,
    input  logic        i_data_ready,
    output logic        o_data_last,
    output logic        o_err_malformed,
    output logic [15:0] o_drop_count
);

    localparam logic [1:0] KIND_MRD  = 2'd0;
    localparam logic [1:0] KIND_MWR  = 2'd1;
    localparam logic [1:0] KIND_CPL  = 2'd2;
    localparam logic [1:0] KIND_CPLD = 2'd3;

    typedef enum logic [2:0] {
        S_H0,
        S_H1,
        S_H2,
        S_H3,
        S_HDR_OUT,
        S_DATA,
        S_DRAIN
    } state_t;

    state_t      state;
    state_t      state_next;

    // Held low through reset so every output, tready included, reads 0 until
    // the first cycle after rst_n is released.
    logic        active;
    logic [1:0]  fmt;
    logic        ep;
    logic        supported;
    logic [10:0] count;

    logic        accept;
    logic        hdr_last;
    logic        oversize;
    logic        drop;
    logic        err_next;
    logic        drop_inc;

    logic [1:0]  dw0_kind;
    logic        dw0_supported;

    logic        unused_inputs;
    assign unused_inputs = ^{m_axis_rx_tkeep, m_axis_rx_tuser[21:9], m_axis_rx_tuser[1:0]};

    // -------------------------------------------------------------------------
    // DW0 {fmt,type} decode
    // -------------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        dw0_kind      = KIND_MRD;
        dw0_supported = 1'b1;
        case (m_axis_rx_tdata[30:24])
            7'h00, 7'h20: dw0_kind = KIND_MRD;
            7'h40, 7'h60: dw0_kind = KIND_MWR;
            7'h0A:        dw0_kind = KIND_CPL;
            7'h4A:        dw0_kind = KIND_CPLD;
            default:      dw0_supported = 1'b0;
        endcase
    end

    assign accept   = m_axis_rx_tvalid && m_axis_rx_tready;
    // 3DW headers end at H2, 4DW headers at H3.
    assign hdr_last = (state == S_H3) || ((state == S_H2) && !fmt[0]);
    assign oversize = fmt[1] && (o_hdr_length > 11'(MAX_PAYLOAD_DW));
    assign drop     = !supported || ep || oversize;

    // -------------------------------------------------------------------------
    // Next-state and stream-side outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_next       = state;
        m_axis_rx_tready = 1'b0;
        o_hdr_valid      = 1'b0;
        o_data           = '0;
        o_data_valid     = 1'b0;
        o_data_last      = 1'b0;
        err_next         = 1'b0;
        drop_inc         = 1'b0;

        if (active) begin
            case (state)
                S_H0, S_H1, S_H2, S_H3: begin
                    m_axis_rx_tready = 1'b1;
                    if (m_axis_rx_tvalid) begin
                        if (hdr_last) begin
                            if (drop) begin
                                drop_inc   = 1'b1;
                                err_next   = oversize;
                                state_next = m_axis_rx_tlast ? S_H0 : S_DRAIN;
                            end else if (m_axis_rx_tlast == fmt[1]) begin
                                // tlast must be high on the last header DW
                                // exactly when there is no payload.
                                err_next   = 1'b1;
                                state_next = m_axis_rx_tlast ? S_H0 : S_DRAIN;
                            end else begin
                                state_next = S_HDR_OUT;
                            end
                        end else if (m_axis_rx_tlast) begin
                            err_next   = 1'b1;
                            state_next = S_H0;
                        end else begin
                            case (state)
                                S_H0:    state_next = S_H1;
                                S_H1:    state_next = S_H2;
                                default: state_next = S_H3;
                            endcase
                        end
                    end
                end

                S_HDR_OUT: begin
                    o_hdr_valid = 1'b1;
                    if (i_hdr_ready) begin
                        state_next = fmt[1] ? S_DATA : S_H0;
                    end
                end

                S_DATA: begin
                    m_axis_rx_tready = i_data_ready;
                    o_data           = m_axis_rx_tdata;
                    o_data_valid     = m_axis_rx_tvalid;
                    o_data_last      = (count == 11'd1) || m_axis_rx_tlast;
                    if (accept) begin
                        if (m_axis_rx_tlast) begin
                            err_next   = (count != 11'd1);
                            state_next = S_H0;
                        end else if (count == 11'd1) begin
                            err_next   = 1'b1;
                            state_next = S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    m_axis_rx_tready = 1'b1;
                    if (m_axis_rx_tvalid && m_axis_rx_tlast) begin
                        state_next = S_H0;
                    end
                end

                default: state_next = S_H0;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State, descriptor capture, counters
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_H0;
            active           <= 1'b0;
            fmt              <= '0;
            ep               <= 1'b0;
            supported        <= 1'b0;
            count            <= '0;
            o_hdr_kind       <= '0;
            o_hdr_length     <= '0;
            o_hdr_req_id     <= '0;
            o_hdr_tag        <= '0;
            o_hdr_first_be   <= '0;
            o_hdr_last_be    <= '0;
            o_hdr_addr       <= '0;
            o_hdr_bar_hit    <= '0;
            o_cpl_status     <= '0;
            o_cpl_byte_count <= '0;
            o_cpl_lower_addr <= '0;
            o_err_malformed  <= 1'b0;
            o_drop_count     <= '0;
        end else begin
            active          <= 1'b1;
            state           <= state_next;
            o_err_malformed <= err_next;

            if (drop_inc && (o_drop_count != 16'hFFFF)) begin
                o_drop_count <= o_drop_count + 16'd1;
            end

            if (accept) begin
                case (state)
                    S_H0: begin
                        fmt              <= m_axis_rx_tdata[30:29];
                        ep               <= m_axis_rx_tdata[14];
                        supported        <= dw0_supported;
                        o_hdr_kind       <= dw0_kind;
                        // A zero length field encodes 1024 DWs.
                        o_hdr_length     <= {(m_axis_rx_tdata[9:0] == 10'd0), m_axis_rx_tdata[9:0]};
                        o_hdr_bar_hit    <= m_axis_rx_tuser[8:2];
                        o_hdr_req_id     <= '0;
                        o_hdr_tag        <= '0;
                        o_hdr_first_be   <= '0;
                        o_hdr_last_be    <= '0;
                        o_hdr_addr       <= '0;
                        o_cpl_status     <= '0;
                        o_cpl_byte_count <= '0;
                        o_cpl_lower_addr <= '0;
                    end
                    S_H1: begin
                        if (o_hdr_kind[1]) begin
                            o_cpl_status     <= m_axis_rx_tdata[15:13];
                            o_cpl_byte_count <= m_axis_rx_tdata[11:0];
                        end else begin
                            o_hdr_req_id   <= m_axis_rx_tdata[31:16];
                            o_hdr_tag      <= m_axis_rx_tdata[15:8];
                            o_hdr_last_be  <= m_axis_rx_tdata[7:4];
                            o_hdr_first_be <= m_axis_rx_tdata[3:0];
                        end
                    end
                    S_H2: begin
                        if (o_hdr_kind[1]) begin
                            o_hdr_req_id     <= m_axis_rx_tdata[31:16];
                            o_hdr_tag        <= m_axis_rx_tdata[15:8];
                            o_cpl_lower_addr <= m_axis_rx_tdata[6:0];
                        end else if (fmt[0]) begin
                            o_hdr_addr[63:32] <= m_axis_rx_tdata;
                        end else begin
                            o_hdr_addr[31:2] <= m_axis_rx_tdata[31:2];
                        end
                    end
                    S_H3: begin
                        o_hdr_addr[31:2] <= m_axis_rx_tdata[31:2];
                    end
                    S_DATA: begin
                        count <= count - 11'd1;
                    end
                    default: ;
                endcase
            end

            if ((state == S_HDR_OUT) && i_hdr_ready) begin
                count <= o_hdr_length;
            end
        end
    end

endmodule

// File: tb/tb_pcie_rx_tlp_parser.sv
// -----------------------------------------------------------------------------
// tb_pcie_rx_tlp_parser
//
// Directed bench for pcie_rx_tlp_parser. A negedge monitor records every
// accepted descriptor, every accepted payload beat and every error pulse; the
// main sequence drives TLPs and compares the recordings with hand-computed
// values.
// -----------------------------------------------------------------------------
module tb_pcie_rx_tlp_parser;

    typedef struct packed {
        logic [1:0]  kind;
        logic [10:0] length;
        logic [15:0] req_id;
        logic [7:0]  tag;
        logic [3:0]  first_be;
        logic [3:0]  last_be;
        logic [63:0] addr;
        logic [6:0]  bar_hit;
        logic [2:0]  status;
        logic [11:0] byte_count;
        logic [6:0]  lower_addr;
    } hdr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m_axis_rx_tdata;
    logic [3:0]  m_axis_rx_tkeep;
    logic        m_axis_rx_tlast;
    logic        m_axis_rx_tvalid;
    logic        m_axis_rx_tready;
    logic [21:0] m_axis_rx_tuser;
    logic        o_hdr_valid;
    logic        i_hdr_ready;
    logic [1:0]  o_hdr_kind;
    logic [10:0] o_hdr_length;
    logic [15:0] o_hdr_req_id;
    logic [7:0]  o_hdr_tag;
    logic [3:0]  o_hdr_first_be;
    logic [3:0]  o_hdr_last_be;
    logic [63:0] o_hdr_addr;
    logic [6:0]  o_hdr_bar_hit;
    logic [2:0]  o_cpl_status;
    logic [11:0] o_cpl_byte_count;
    logic [6:0]  o_cpl_lower_addr;
    logic [31:0] o_data;
    logic        o_data_valid;
    logic        i_data_ready;
    logic        o_data_last;
    logic        o_err_malformed;
    logic [15:0] o_drop_count;

    int          total = 0;
    int          bad = 0;
    int          err_seen = 0;
    hdr_t        hdr_q[$];
    logic [32:0] data_q[$];

    always #5 clk = ~clk;

    pcie_rx_tlp_parser #(.MAX_PAYLOAD_DW(128)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .m_axis_rx_tdata  (m_axis_rx_tdata),
        .m_axis_rx_tkeep  (m_axis_rx_tkeep),
        .m_axis_rx_tlast  (m_axis_rx_tlast),
        .m_axis_rx_tvalid (m_axis_rx_tvalid),
        .m_axis_rx_tready (m_axis_rx_tready),
        .m_axis_rx_tuser  (m_axis_rx_tuser),
        .o_hdr_valid      (o_hdr_valid),
        .i_hdr_ready      (i_hdr_ready),
        .o_hdr_kind       (o_hdr_kind),
        .o_hdr_length     (o_hdr_length),
        .o_hdr_req_id     (o_hdr_req_id),
        .o_hdr_tag        (o_hdr_tag),
        .o_hdr_first_be   (o_hdr_first_be),
        .o_hdr_last_be    (o_hdr_last_be),
        .o_hdr_addr       (o_hdr_addr),
        .o_hdr_bar_hit    (o_hdr_bar_hit),
        .o_cpl_status     (o_cpl_status),
        .o_cpl_byte_count (o_cpl_byte_count),
        .o_cpl_lower_addr (o_cpl_lower_addr),
        .o_data           (o_data),
        .o_data_valid     (o_data_valid),
        .i_data_ready     (i_data_ready),
        .o_data_last      (o_data_last),
        .o_err_malformed  (o_err_malformed),
        .o_drop_count     (o_drop_count)
    );

    // Monitor: samples on the falling edge, where inputs and outputs are settled.
    always @(negedge clk) begin
        hdr_t h;
        if (o_hdr_valid && i_hdr_ready) begin
            h.kind       = o_hdr_kind;
            h.length     = o_hdr_length;
            h.req_id     = o_hdr_req_id;
            h.tag        = o_hdr_tag;
            h.first_be   = o_hdr_first_be;
            h.last_be    = o_hdr_last_be;
            h.addr       = o_hdr_addr;
            h.bar_hit    = o_hdr_bar_hit;
            h.status     = o_cpl_status;
            h.byte_count = o_cpl_byte_count;
            h.lower_addr = o_cpl_lower_addr;
            hdr_q.push_back(h);
        end
        if (o_data_valid && i_data_ready) begin
            data_q.push_back({o_data_last, o_data});
        end
        if (o_err_malformed) begin
            err_seen++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until the DUT accepts it (bounded wait).
    task automatic send(input logic [31:0] d, input logic l);
        int  n;
        logic acc;
        n = 0;
        m_axis_rx_tdata  = d;
        m_axis_rx_tlast  = l;
        m_axis_rx_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            acc = m_axis_rx_tready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 50) begin
                total++;
                bad++;
                $error("FAIL send_timeout: beat %0h not accepted after %0d cycles", d, n);
                break;
            end
        end
        m_axis_rx_tvalid = 1'b0;
        m_axis_rx_tlast  = 1'b0;
        m_axis_rx_tdata  = '0;
    endtask

    task automatic get_hdr(output hdr_t h);
        if (hdr_q.size() != 0) h = hdr_q.pop_front();
        else h = 'x;
    endtask

    task automatic expect_data(input string tag, input logic [32:0] exp);
        logic [32:0] got;
        if (data_q.size() != 0) got = data_q.pop_front();
        else got = 'x;
        check(tag, got, exp);
    endtask

    initial begin
        hdr_t h;
        int   e0;

        rst_n            = 1'b0;
        m_axis_rx_tdata  = '0;
        m_axis_rx_tkeep  = 4'hF;
        m_axis_rx_tlast  = 1'b0;
        m_axis_rx_tvalid = 1'b0;
        m_axis_rx_tuser  = 22'h000004;   // BAR hit field = 7'h01
        i_hdr_ready      = 1'b1;
        i_data_ready     = 1'b1;

        // ---------------- reset state ----------------
        idle(3);
        @(negedge clk);
        check("rst_tready", m_axis_rx_tready, 0);
        check("rst_hdr_valid", o_hdr_valid, 0);
        check("rst_data_valid", o_data_valid, 0);
        check("rst_drop_count", o_drop_count, 0);
        check("rst_err", o_err_malformed, 0);
        check("rst_addr", o_hdr_addr, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_tready_still_low", m_axis_rx_tready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("tready_after_reset", m_axis_rx_tready, 1);
        @(posedge clk);
        #1;

        // ---------------- 3DW MWr, 4 DW payload ----------------
        e0 = err_seen;
        send(32'h40000004, 1'b0);
        send(32'h01000A0F, 1'b0);
        send(32'h00001000, 1'b0);
        send(32'h00000011, 1'b0);
        send(32'h00000022, 1'b0);
        send(32'h00000033, 1'b0);
        send(32'h00000044, 1'b1);
        idle(2);
        check("t1_hdr_count", hdr_q.size(), 1);
        get_hdr(h);
        check("t1_kind", h.kind, 1);
        check("t1_length", h.length, 4);
        check("t1_req_id", h.req_id, 16'h0100);
        check("t1_tag", h.tag, 8'h0A);
        check("t1_first_be", h.first_be, 4'hF);
        check("t1_last_be", h.last_be, 4'h0);
        check("t1_addr", h.addr, 64'h1000);
        check("t1_bar_hit", h.bar_hit, 7'h01);
        check("t1_data_count", data_q.size(), 4);
        expect_data("t1_d0", {1'b0, 32'h11});
        expect_data("t1_d1", {1'b0, 32'h22});
        expect_data("t1_d2", {1'b0, 32'h33});
        expect_data("t1_d3", {1'b1, 32'h44});
        check("t1_err", err_seen - e0, 0);

        // ---------------- 3DW MRd, header held off for 5 cycles ----------------
        i_hdr_ready = 1'b0;
        send(32'h00000001, 1'b0);
        send(32'h02000501, 1'b0);
        send(32'h00002004, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_hold_tready", m_axis_rx_tready, 0);
            check("t2_hold_valid", o_hdr_valid, 1);
            check("t2_hold_addr", o_hdr_addr, 64'h2004);
            check("t2_hold_tag", o_hdr_tag, 8'h05);
            check("t2_hold_data_valid", o_data_valid, 0);
            @(posedge clk);
            #1;
        end
        i_hdr_ready = 1'b1;
        idle(2);
        check("t2_hdr_count", hdr_q.size(), 1);
        get_hdr(h);
        check("t2_kind", h.kind, 0);
        check("t2_length", h.length, 1);
        check("t2_req_id", h.req_id, 16'h0200);
        check("t2_first_be", h.first_be, 4'h1);
        check("t2_no_data", data_q.size(), 0);

        // ---------------- 4DW MWr, 64-bit address ----------------
        send(32'h60000001, 1'b0);
        send(32'h03001201, 1'b0);
        send(32'h00000001, 1'b0);
        send(32'h00002000, 1'b0);
        send(32'hDEADBEEF, 1'b1);
        idle(2);
        check("t3_hdr_count", hdr_q.size(), 1);
        get_hdr(h);
        check("t3_kind", h.kind, 1);
        check("t3_addr", h.addr, 64'h0000_0001_0000_2000);
        check("t3_tag", h.tag, 8'h12);
        expect_data("t3_d0", {1'b1, 32'hDEADBEEF});

        // ---------------- CplD, 2 DW ----------------
        send(32'h4A000002, 1'b0);
        send(32'hABCD0008, 1'b0);
        send(32'h01000A10, 1'b0);
        send(32'h000000A1, 1'b0);
        send(32'h000000A2, 1'b1);
        idle(2);
        check("t4_hdr_count", hdr_q.size(), 1);
        get_hdr(h);
        check("t4_kind", h.kind, 3);
        check("t4_length", h.length, 2);
        check("t4_status", h.status, 0);
        check("t4_byte_count", h.byte_count, 12'd8);
        check("t4_lower_addr", h.lower_addr, 7'h10);
        check("t4_req_id", h.req_id, 16'h0100);
        check("t4_tag", h.tag, 8'h0A);
        check("t4_first_be", h.first_be, 4'h0);
        check("t4_data_count", data_q.size(), 2);
        expect_data("t4_d0", {1'b0, 32'hA1});
        expect_data("t4_d1", {1'b1, 32'hA2});

        // ---------------- MWr len 4 with early tlast on payload DW 2 ----------------
        e0 = err_seen;
        send(32'h40000004, 1'b0);
        send(32'h01000B0F, 1'b0);
        send(32'h00003000, 1'b0);
        send(32'h00000055, 1'b0);
        send(32'h00000066, 1'b1);
        idle(2);
        check("t5_err", err_seen - e0, 1);
        check("t5_hdr_count", hdr_q.size(), 1);
        get_hdr(h);
        check("t5_length", h.length, 4);
        check("t5_data_count", data_q.size(), 2);
        expect_data("t5_d0", {1'b0, 32'h55});
        expect_data("t5_d1", {1'b1, 32'h66});
        // following MRd must parse normally
        send(32'h00000002, 1'b0);
        send(32'h04000C0F, 1'b0);
        send(32'h00004000, 1'b1);
        idle(2);
        check("t5_next_hdr_count", hdr_q.size(), 1);
        get_hdr(h);
        check("t5_next_kind", h.kind, 0);
        check("t5_next_length", h.length, 2);
        check("t5_next_tag", h.tag, 8'h0C);
        check("t5_next_addr", h.addr, 64'h4000);

        // ---------------- poisoned MWr, then message TLP ----------------
        e0 = err_seen;
        send(32'h40004001, 1'b0);
        send(32'h01000D0F, 1'b0);
        send(32'h00005000, 1'b0);
        send(32'h00000077, 1'b1);
        send(32'h34000000, 1'b0);
        send(32'h00000000, 1'b0);
        send(32'h00000000, 1'b0);
        send(32'h00000000, 1'b1);
        idle(2);
        check("t6_drop_count", o_drop_count, 2);
        check("t6_no_hdr", hdr_q.size(), 0);
        check("t6_no_data", data_q.size(), 0);
        check("t6_err", err_seen - e0, 0);

        // ---------------- reset during H2 of an MRd ----------------
        e0 = err_seen;
        send(32'h00000001, 1'b0);
        send(32'h05000E0F, 1'b0);
        m_axis_rx_tdata  = 32'h00006000;
        m_axis_rx_tlast  = 1'b1;
        m_axis_rx_tvalid = 1'b1;
        rst_n            = 1'b0;
        @(posedge clk);
        #1;
        m_axis_rx_tvalid = 1'b0;
        m_axis_rx_tlast  = 1'b0;
        m_axis_rx_tdata  = '0;
        @(negedge clk);
        check("t7_rst_tready", m_axis_rx_tready, 0);
        check("t7_rst_drop_count", o_drop_count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        check("t7_no_hdr", hdr_q.size(), 0);
        check("t7_err", err_seen - e0, 0);
        send(32'h00000001, 1'b0);
        send(32'h06000F0F, 1'b0);
        send(32'h00006000, 1'b1);
        idle(2);
        check("t7_hdr_count", hdr_q.size(), 1);
        get_hdr(h);
        check("t7_req_id", h.req_id, 16'h0600);
        check("t7_tag", h.tag, 8'h0F);
        check("t7_addr", h.addr, 64'h6000);

        // ---------------- oversize MWr (129 DW > 128) ----------------
        e0 = err_seen;
        send(32'h40000081, 1'b0);
        send(32'h01000000, 1'b0);
        send(32'h00007000, 1'b0);
        send(32'h00000001, 1'b0);
        send(32'h00000002, 1'b1);
        idle(2);
        check("t8_err", err_seen - e0, 1);
        check("t8_drop_count", o_drop_count, 1);
        check("t8_no_hdr", hdr_q.size(), 0);
        check("t8_no_data", data_q.size(), 0);

        // ---------------- MRd missing tlast on last header DW ----------------
        e0 = err_seen;
        send(32'h00000001, 1'b0);
        send(32'h07000000, 1'b0);
        send(32'h00008000, 1'b0);
        send(32'h00000000, 1'b1);
        idle(2);
        check("t9_err", err_seen - e0, 1);
        check("t9_no_hdr", hdr_q.size(), 0);

        // ---------------- tlast on DW1 of an MWr ----------------
        e0 = err_seen;
        send(32'h40000001, 1'b0);
        send(32'h01000000, 1'b1);
        idle(2);
        check("t10_err", err_seen - e0, 1);
        check("t10_no_hdr", hdr_q.size(), 0);
        check("t10_drop_count", o_drop_count, 1);

        // ---------------- Cpl without data, length field 0 = 1024 ----------------
        send(32'h0A000000, 1'b0);
        send(32'h00002004, 1'b0);
        send(32'h09001103, 1'b1);
        idle(2);
        check("t11_hdr_count", hdr_q.size(), 1);
        get_hdr(h);
        check("t11_kind", h.kind, 2);
        check("t11_length", h.length, 11'd1024);
        check("t11_status", h.status, 3'd1);
        check("t11_byte_count", h.byte_count, 12'd4);
        check("t11_lower_addr", h.lower_addr, 7'h03);
        check("t11_req_id", h.req_id, 16'h0900);
        check("t11_tag", h.tag, 8'h11);
        check("t11_no_data", data_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
